edge_seq: RTL

EDGE_SEQ -- requirements
Module: edge_seq

---
 rtl/edge_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/edge_seq.sv
// Frame sequencer for an edge-detect engine: loads pixels into the source BRAM,
// releases the engine, then streams the result BRAM out one pixel at a time.
module edge_seq #(
    parameter int H   = 500,
    parameter int V   = 500,
    parameter int TMO = 2500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        src_we,
    output logic [17:0] src_addr,
    output logic [7:0]  src_din,
    output logic        eng_rst,
    input  logic        eng_ready,
    output logic [17:0] dst_addr,
    input  logic [7:0]  dst_dout,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int N  = H * V;
    localparam int RW = $clog2(TMO + 1);
    localparam logic [17:0]   LAST     = 18'(N - 1);
    localparam logic [RW-1:0] TMO_LAST = RW'(TMO - 1);
    localparam logic [RW-1:0] RUN_MIN  = RW'(2);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, RD, CAP, SEND} state_t;

    state_t        state, state_n;
    logic [17:0]   cnt, cnt_n;
    logic [RW-1:0] run, run_n;
    logic          err_n, done_n, we_n;
    logic [17:0]   addr_n;
    logic [7:0]    din_n, data_n;

    assign ld_ready  = (state == LOAD);
    assign eng_rst   = (state != RUN);
    assign busy      = (state != IDLE);
    assign out_valid = (state == SEND);
    // cnt never passes N-1, so the read address is always in range
    assign dst_addr  = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            run      <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
            src_we   <= 1'b0;
            src_addr <= '0;
            src_din  <= '0;
            out_data <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            run      <= run_n;
            err      <= err_n;
            done     <= done_n;
            src_we   <= we_n;
            src_addr <= addr_n;
            src_din  <= din_n;
            out_data <= data_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        run_n   = run;
        err_n   = err;
        done_n  = 1'b0;
        we_n    = 1'b0;
        addr_n  = src_addr;
        din_n   = src_din;
        data_n  = out_data;
        // abort beats any handshake in flight; that transfer is dropped
        if (abort && state != IDLE) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (start && !abort) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                    err_n   = 1'b0;
                end
                LOAD: if (ld_valid) begin
                    we_n   = 1'b1;
                    addr_n = cnt;
                    din_n  = ld_data;
                    if (cnt == LAST) begin
                        state_n = RUN;
                        cnt_n   = '0;
                        run_n   = '0;
                    end else begin
                        cnt_n = cnt + 18'd1;
                    end
                end
                RUN: begin
                    run_n = run + 1'b1;
                    // eng_ready is untrusted while the engine comes out of hold
                    if (run >= RUN_MIN && eng_ready) begin
                        state_n = RD;
                    end else if (run == TMO_LAST) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end
                end
                RD:  state_n = CAP;
                CAP: begin
                    data_n  = dst_dout;
                    state_n = SEND;
                end
                SEND: if (out_ready) begin
                    if (cnt == LAST) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        state_n = RD;
                        cnt_n   = cnt + 18'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule
